// File: rtl/reg_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : reg_wb_queue
// Brief    : In-order register-file write-back queue with pending-write
//            forwarding. Define REG_WB_COALESCE_EN to merge a request into the
//            youngest queued entry when the addresses match.
// Revision : 1.0 - initial release
// ============================================================================
module reg_wb_queue #(
  parameter int PW    = 3,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [PW-1:0]              req_addr,
  input  logic [DW-1:0]              req_data,
  input  logic                       stall,
  output logic                       wr_en,
  output logic [PW-1:0]              wr_addr,
  output logic [DW-1:0]              dat_in,
  input  logic [PW-1:0]              lookup_addr,
  output logic                       lookup_hit,
  output logic [DW-1:0]              lookup_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_wr_en;
  logic [PW-1:0] r_wr_addr;
  logic [DW-1:0] r_dat_in;

  logic          w_pop;
  logic          w_coal_hit;
  logic          w_ready;
  logic          w_alloc;
  logic          w_merge;
  logic [AW-1:0] w_young;
  logic          w_hit;
  logic [DW-1:0] w_ldata;

  assign w_pop   = (r_count != '0) && !stall;
  assign w_young = r_tail - AW'(1);

`ifdef REG_WB_COALESCE_EN
  // The youngest entry is only off-limits when it is also the head being popped.
  assign w_coal_hit = (r_count != '0) && (r_addr[w_young] == req_addr) &&
                      !(w_pop && (r_count == CW'(1)));
`else
  assign w_coal_hit = 1'b0;
`endif

  assign w_ready = (r_count != CW'(DEPTH)) || w_coal_hit;
  assign w_alloc = req_valid && w_ready && !w_coal_hit;
  assign w_merge = req_valid && w_coal_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_dat_in  <= '0;
    end else begin
      r_wr_en <= w_pop;
      if (w_pop) begin
        r_wr_addr <= r_addr[r_head];
        r_dat_in  <= r_data[r_head];
        r_head    <= r_head + AW'(1);
      end
      if (w_alloc) begin
        r_tail <= r_tail + AW'(1);
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= req_addr;
      r_data[r_tail] <= req_data;
    end else if (w_merge) begin
      r_data[w_young] <= req_data;
    end
  end

  // Walk oldest to youngest so the last match wins; the output register is the oldest source.
  always_comb begin
    w_hit   = r_wr_en && (r_wr_addr == lookup_addr);
    w_ldata = w_hit ? r_dat_in : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_addr[r_head + AW'(i)] == lookup_addr)) begin
        w_hit   = 1'b1;
        w_ldata = r_data[r_head + AW'(i)];
      end
    end
  end

  assign req_ready   = w_ready;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign dat_in      = r_dat_in;
  assign lookup_hit  = w_hit;
  assign lookup_data = w_ldata;
  assign count       = r_count;

endmodule
`default_nettype wire
